// File: rtl/uart_tx.sv
// uart_tx: FIFO-fed UART serializer (start, DBIT data LSB first, optional even parity, stop).
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            fifo_empty,
    input  logic [DBIT-1:0] fifo_data,
    output logic            fifo_rd,
    output logic            tx,
    output logic            tx_busy
);
    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
    state_t          state, state_next;
    logic [SW-1:0]   s_reg, s_next;
    logic [NW-1:0]   n_reg, n_next;
    logic [DBIT-1:0] b_reg, b_next;
    logic            tx_reg, tx_next;
`ifdef UART_TX_PARITY_EN
    logic            p_reg, p_next;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            s_reg  <= '0;
            n_reg  <= '0;
            b_reg  <= '0;
            tx_reg <= 1'b1;
`ifdef UART_TX_PARITY_EN
            p_reg  <= 1'b0;
`endif
        end else begin
            state  <= state_next;
            s_reg  <= s_next;
            n_reg  <= n_next;
            b_reg  <= b_next;
            tx_reg <= tx_next;
`ifdef UART_TX_PARITY_EN
            p_reg  <= p_next;
`endif
        end
    end

    // tx_next follows the current state, so the line lags every state change by exactly one clk
    always_comb begin
        state_next = state;
        s_next     = s_reg;
        n_next     = n_reg;
        b_next     = b_reg;
        tx_next    = tx_reg;
        fifo_rd    = 1'b0;
`ifdef UART_TX_PARITY_EN
        p_next     = p_reg;
`endif
        case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (!fifo_empty) begin
                    fifo_rd    = ~reset;
                    b_next     = fifo_data;
                    s_next     = '0;
                    state_next = START;
`ifdef UART_TX_PARITY_EN
                    p_next     = ^fifo_data;
`endif
                end
            end
            START: begin
                tx_next = 1'b0;
                if (s_tick) begin
                    if (s_reg == SW'(15)) begin
                        s_next     = '0;
                        n_next     = '0;
                        state_next = DATA;
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end
            DATA: begin
                tx_next = b_reg[0];
                if (s_tick) begin
                    if (s_reg == SW'(15)) begin
                        s_next = '0;
                        b_next = b_reg >> 1;
                        if (n_reg == NW'(DBIT - 1))
`ifdef UART_TX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        else
                            n_next = n_reg + 1'b1;
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx_next = p_reg;
                if (s_tick) begin
                    if (s_reg == SW'(15)) begin
                        s_next     = '0;
                        state_next = STOP;
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                tx_next = 1'b1;
                if (s_tick) begin
                    if (s_reg == SW'(SB_TICK - 1))
                        state_next = IDLE;
                    else
                        s_next = s_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign tx      = tx_reg;
    assign tx_busy = (state != IDLE);
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: vector table, directed corner sequences and random frames checked by a tick-counting line decoder.
module tb_uart_tx;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam logic [10:0] FMASK = 11'((1 << NB) - 1);

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       s_tick = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data = '0;
    logic       fifo_rd, tx, tx_busy;

    uart_tx #(.DBIT(8), .SB_TICK(16)) dut (
        .clk(clk), .reset(reset), .s_tick(s_tick), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_rd(fifo_rd), .tx(tx), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    int vecs = 0, miss = 0;
    int pop_count = 0, pushes = 0;
    logic pop_pending = 1'b0;
    logic [7:0] q[$];
    logic [7:0] exp_q[$];
    int tick_en = 0, tick_mode = 0, tdiv = 16, tcnt = 0;
    int tmo = 5000;

    logic [10:0] rx_frames[256];
    int rx_cnt = 0, rd_idx = 0;

    always @(posedge clk or posedge reset)
        if (reset) pop_pending <= 1'b0;
        else begin
            pop_pending <= fifo_rd;
            if (fifo_rd) pop_count <= pop_count + 1;
        end

    // Line decoder: counts ticks from the falling start edge and samples each bit at its middle
    initial begin
        bit rx_on = 0;
        logic prev_tx = 1'b1;
        int rx_ticks = 0;
        logic [10:0] rx_bits = '1;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                rx_on = 0;
                prev_tx = 1'b1;
            end else begin
                if (!rx_on) begin
                    if (prev_tx && !tx) begin
                        rx_on = 1;
                        rx_ticks = s_tick ? 1 : 0;
                        rx_bits = '1;
                    end
                end else if (s_tick) begin
                    rx_ticks++;
                    if (rx_ticks >= 8 && (rx_ticks - 8) % 16 == 0) begin
                        rx_bits[(rx_ticks - 8) / 16] = tx;
                        if ((rx_ticks - 8) / 16 == NB - 1) begin
                            rx_frames[rx_cnt % 256] = rx_bits;
                            rx_cnt++;
                            rx_on = 0;
                        end
                    end
                end
                prev_tx = tx;
            end
        end
    end

    function automatic logic [10:0] frame_of(input logic [7:0] d);
        logic [10:0] f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1 + i] = d[i];
`ifdef UART_TX_PARITY_EN
        f[9] = ^d;
`endif
        return f & FMASK;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic refresh();
        fifo_empty = (q.size() == 0);
        fifo_data = fifo_empty ? 8'($urandom) : q[0];
    endtask

    task automatic step();
        @(negedge clk);
        if (pop_pending && q.size() > 0) void'(q.pop_front());
        if (tick_mode == 0) begin
            s_tick = (tick_en != 0) && (tcnt == 0);
            tcnt = (tcnt + 1) % tdiv;
        end else begin
            s_tick = (tick_en != 0) && ($urandom_range(0, 2) == 0);
        end
        refresh();
    endtask

    task automatic push(input logic [7:0] w);
        q.push_back(w);
        exp_q.push_back(w);
        pushes++;
        refresh();
    endtask

    task automatic wait_rx(output logic [10:0] f, output bit ok);
        int t = 0;
        while (rx_cnt <= rd_idx && t < tmo) begin
            step();
            t++;
        end
        ok = (rx_cnt > rd_idx);
        f = ok ? (rx_frames[rd_idx % 256] & FMASK) : '0;
        if (ok) rd_idx++;
        else begin
            chk("rx_timeout", rx_cnt, rd_idx + 1);
            tmo = 50;
        end
    endtask

    task automatic check_rx(input int n);
        logic [10:0] f;
        bit ok;
        for (int k = 0; k < n; k++) begin
            wait_rx(f, ok);
            if (ok && exp_q.size() > 0) chk("rx_frame", f, frame_of(exp_q.pop_front()));
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    initial begin
        vec_t tbl[8];
        int bad, blen, p0, gap, ticks;
        bit seen, ok;
        logic [10:0] fb, ef, f;
        logic e;
        tbl[0] = '{8'h55, 1'b0};
        tbl[1] = '{8'hA3, 1'b0};
        tbl[2] = '{8'h0F, 1'b0};
        tbl[3] = '{8'h07, 1'b1};
        tbl[4] = '{8'h03, 1'b0};
        tbl[5] = '{8'h00, 1'b0};
        tbl[6] = '{8'hFF, 1'b0};
        tbl[7] = '{8'h80, 1'b1};

        // reset state, including a non-empty FIFO that must not be popped while reset is held
        #1 reset = 1'b1;
        step();
        q.push_back(8'h5A);
        refresh();
        step();
        chk("rst_tx", tx, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_rd", fifo_rd, 0);
        q.delete();
        refresh();
        step();
        reset = 1'b0;
        chk("rst_pops", pop_count, 0);

        // empty FIFO for 1000 clk
        tick_mode = 0; tdiv = 16; tick_en = 1;
        bad = 0;
        for (int j = 0; j < 1000; j++) begin
            step();
            if (tx !== 1'b1 || fifo_rd !== 1'b0 || tx_busy !== 1'b0) bad++;
        end
        chk("idle_hold", bad, 0);
        chk("idle_pops", pop_count, 0);

        // 0x55 with the pop edge aligned to a tick: exact 256-clk bit cells
        for (int j = 0; j < 40 && s_tick !== 1'b1; j++) step();
        push(8'h55);
        p0 = pop_count;
        fb = frame_of(8'h55);
        bad = 0; blen = 0;
        for (int j = 0; j < NB * 256 + 20; j++) begin
            step();
            e = (j == 0 || j > NB * 256) ? 1'b1 : fb[(j - 1) / 256];
            if (tx !== e) bad++;
            if (tx_busy) blen++;
        end
        chk("wave_55", bad, 0);
        chk("busy_len", blen, NB * 256);
        chk("pops_55", pop_count - p0, 1);
        check_rx(1);

        // s_tick stalled mid-START for 500 clk
        push(8'hC5);
        ticks = 0;
        for (int j = 0; j < 200 && ticks < 5; j++) begin
            step();
            if (s_tick) ticks++;
        end
        tick_en = 0;
        bad = 0;
        for (int j = 0; j < 500; j++) begin
            step();
            if (tx !== 1'b0 || tx_busy !== 1'b1) bad++;
        end
        chk("stall_start", bad, 0);
        tick_en = 1;
        check_rx(1);

        // back-to-back frames: exactly one IDLE cycle between them
        tdiv = 2;
        p0 = pop_count;
        push(8'hA3);
        push(8'h0F);
        gap = 0; seen = 0;
        for (int j = 0; j < 2000 && pop_count - p0 < 2; j++) begin
            step();
            if (tx_busy) seen = 1;
            if (seen && !tx_busy && pop_count - p0 == 1) gap++;
        end
        chk("b2b_gap", gap, 1);
        check_rx(2);
        chk("b2b_pops", pop_count - p0, 2);

        // reset during data bit 3 of 0xFF
        p0 = pop_count;
        push(8'hFF);
        ticks = 0;
        for (int j = 0; j < 400 && ticks < 72; j++) begin
            step();
            if (s_tick) ticks++;
        end
        chk("pre_rst_busy", tx_busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_busy", tx_busy, 0);
        chk("mid_rst_rd", fifo_rd, 0);
        repeat (3) step();
        reset = 1'b0;
        exp_q.delete();
        bad = 0;
        for (int j = 0; j < 100; j++) begin
            step();
            if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        chk("post_rst_idle", bad, 0);
        chk("post_rst_pops", pop_count - p0, 1);
        push(8'h3C);
        check_rx(1);

        // table vectors with irregular tick spacing
        tick_mode = 1;
        for (int i = 0; i < 8; i++) begin
            push(tbl[i].data);
            wait_rx(f, ok);
`ifdef UART_TX_PARITY_EN
            ef = {1'b1, tbl[i].par, tbl[i].data, 1'b0};
`else
            ef = {1'b0, 1'b1, tbl[i].data, 1'b0};
`endif
            if (ok) chk("tbl_frame", f, ef & FMASK);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end

        // random words in random bursts
        for (int k = 0; k < 40; k++) begin
            push(8'($urandom));
            repeat ($urandom_range(0, 3) == 0 ? $urandom_range(0, 400) : 0) step();
        end
        check_rx(exp_q.size());
        repeat (20) step();
        chk("fifo_drained", q.size(), 0);
        chk("pops_total", pop_count, pushes);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
